// File: rtl/bcd_display_scanner.sv
// Four-digit multiplexed 7-segment scanner: shadow-registered BCD digits,
// prescaled digit rotation, frame pulse, leading-zero blanking and a sticky
// invalid-BCD error flag.
module bcd_display_scanner #(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits,
  input  logic        load,
  input  logic        blank_lz,
  input  logic        clear_err,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic [1:0]  digit_idx,
  output logic        frame,
  output logic        err
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0] prescaler_q, prescaler_d;
  logic [1:0]    idx_q, idx_d;
  logic          frame_q, frame_d;
  logic [15:0]   shadow_q, shadow_d;
  logic          err_q, err_d;

  logic [3:0]    nib_bad;
  logic [3:1]    nib_zero;
  logic [3:1]    upper_zero;
  logic [3:0]    cur_nib;
  logic          blank_cur;
  logic          step_last;

  // Per-nibble classification of incoming digits and of the shadow copy.
  for (genvar gi = 0; gi < 4; gi++) begin : g_bad
    assign nib_bad[gi] = (digits[gi*4 +: 4] > 4'd9);
  end

  for (genvar gi = 1; gi < 4; gi++) begin : g_zero
    assign nib_zero[gi] = (shadow_q[gi*4 +: 4] == 4'd0);
  end

  // upper_zero[i]: nibbles i..3 of the shadow are all zero.
  assign upper_zero[3] = nib_zero[3];
  for (genvar gi = 1; gi < 3; gi++) begin : g_upper
    assign upper_zero[gi] = nib_zero[gi] & upper_zero[gi+1];
  end

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  assign step_last = (prescaler_q == PS_LAST);

  always_comb begin
    prescaler_d = prescaler_q;
    idx_d       = idx_q;
    frame_d     = 1'b0;
    shadow_d    = shadow_q;
    err_d       = err_q;

    if (step_last) begin
      prescaler_d = '0;
      idx_d       = idx_q + 2'd1;
      frame_d     = (idx_q == 2'd3);
    end else begin
      prescaler_d = prescaler_q + PW'(1);
    end

    if (load) begin
      shadow_d = digits;
    end

    // A set on the same edge as a clear takes priority.
    if (load && (|nib_bad)) begin
      err_d = 1'b1;
    end else if (clear_err) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler_q <= '0;
      idx_q       <= 2'd0;
      frame_q     <= 1'b0;
      shadow_q    <= 16'h0000;
      err_q       <= 1'b0;
    end else begin
      prescaler_q <= prescaler_d;
      idx_q       <= idx_d;
      frame_q     <= frame_d;
      shadow_q    <= shadow_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    cur_nib   = shadow_q[idx_q*4 +: 4];
    blank_cur = 1'b0;
    if (blank_lz && (idx_q != 2'd0)) begin
      blank_cur = upper_zero[idx_q];
    end
  end

  assign seg       = blank_cur ? 7'b0000000 : bcd_to_seg(cur_nib);
  assign an        = 4'b0001 << idx_q;
  assign digit_idx = idx_q;
  assign frame     = frame_q;
  assign err       = err_q;

endmodule
